fetch_unit: RTL and testbench

Instruction-fetch stage of the 64-bit five-stage pipeline. It directly feeds the IF/ID pipeline register. It owns the program counter and issues one instruction-memory read at a time, holding the fetched word until the decode side accepts it. Branch/jump redirects from later stages override it and discard any response still in flight.

---
 rtl/fetch_if.sv | 27 ++
 rtl/fetch_unit.sv | 93 +++++++++
 tb/tb_fetch_unit.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// Fetch-stage bus: instruction-memory request/response and IF/ID-facing outputs.
// master is the fetch unit; slave is the surrounding pipeline and memory.
interface fetch_if;
  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;

  logic            stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rvalid;
  logic [ILEN-1:0] imem_rdata;
  logic            if_valid;
  logic [ILEN-1:0] if_inst;
  logic [XLEN-1:0] if_pc;

  modport master (
    input  stall, redirect_valid, redirect_pc, imem_rvalid, imem_rdata,
    output imem_req, imem_addr, if_valid, if_inst, if_pc
  );

  modport slave (
    output stall, redirect_valid, redirect_pc, imem_rvalid, imem_rdata,
    input  imem_req, imem_addr, if_valid, if_inst, if_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the pc, issues one imem read at a time and
// holds the fetched word for decode; redirects flush any in-flight response.
module fetch_unit #(
  parameter logic [63:0] PC_RESET = 64'h0,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic     clk,
  input  logic     arst,
  fetch_if.master  bus
);
  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, FULL, FLUSH} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            valid_q, valid_d;
  logic [ILEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] ifpc_q, ifpc_d;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= IDLE;
      pc_q    <= PC_RESET;
      valid_q <= 1'b0;
      inst_q  <= NOP_INST;
      ifpc_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      inst_q  <= inst_d;
      ifpc_q  <= ifpc_d;
    end
  end

  // Next state; rvalid outside WAIT/FLUSH is ignored.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    inst_d  = inst_q;
    ifpc_d  = ifpc_q;

    case (state_q)
      IDLE: state_d = REQ;
      REQ:  state_d = WAIT;
      WAIT: begin
        if (bus.imem_rvalid) begin
          inst_d  = bus.imem_rdata;
          ifpc_d  = pc_q;
          valid_d = 1'b1;
          pc_d    = pc_q + PC_STEP;
          state_d = FULL;
        end
      end
      FULL: begin
        if (!bus.stall) begin
          valid_d = 1'b0;
          inst_d  = NOP_INST;
          state_d = REQ;
        end
      end
      FLUSH: begin
        if (bus.imem_rvalid) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase

    // Redirect beats stall; an outstanding request forces a flush.
    if (bus.redirect_valid) begin
      pc_d    = bus.redirect_pc & ALIGN_MASK;
      valid_d = 1'b0;
      inst_d  = NOP_INST;
      ifpc_d  = ifpc_q;
      case (state_q)
        REQ:     state_d = FLUSH;
        WAIT:    state_d = bus.imem_rvalid ? REQ : FLUSH;
        FLUSH:   state_d = bus.imem_rvalid ? REQ : FLUSH;
        default: state_d = REQ;
      endcase
    end
  end

  assign bus.imem_req  = (state_q == REQ);
  assign bus.imem_addr = pc_q;
  assign bus.if_valid  = valid_q;
  assign bus.if_inst   = inst_q;
  assign bus.if_pc     = ifpc_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected requests/instructions are queued by
// the directed sequence and popped by independent monitors.
module tb_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] pc;
  } inst_t;

  typedef struct {
    int          due;
    logic [31:0] data;
  } resp_t;

  logic clk;
  logic arst;
  logic arst_b;

  int checks = 0;
  int errors = 0;
  int lat    = 1;
  int cyc    = 0;

  logic [63:0] exp_req_a[$];
  inst_t       exp_inst_a[$];
  logic [63:0] exp_req_b[$];
  inst_t       exp_inst_b[$];
  resp_t       pend_a[$];

  fetch_if ifa();
  fetch_if ifb();

  fetch_unit #(.PC_RESET(64'h0), .NOP_INST(NOP)) u_dut_a (
    .clk(clk), .arst(arst), .bus(ifa)
  );

  fetch_unit #(.PC_RESET(64'hFFFF_FFFF_FFFF_FFFC), .NOP_INST(NOP)) u_dut_b (
    .clk(clk), .arst(arst_b), .bus(ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: address 0 holds addi x1,x0,5; elsewhere a tagged pattern.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == 64'h0) return 32'h0050_0093;
    return {a[27:0], 4'h3};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_valid(input int budget, input string nm);
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (ifa.if_valid) return;
    end
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected if_valid within %0d cycles", nm, budget);
  endtask

  task automatic wait_req(input int budget, input string nm);
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (ifa.imem_req) return;
    end
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected imem_req within %0d cycles", nm, budget);
  endtask

  // Memory A: variable latency, one response per captured request.
  always @(negedge clk) begin
    if (ifa.imem_req) pend_a.push_back('{due: cyc + lat, data: mem_word(ifa.imem_addr)});
  end

  initial begin
    ifa.imem_rvalid = 1'b0;
    ifa.imem_rdata  = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (pend_a.size() != 0 && pend_a[0].due == cyc) begin
        ifa.imem_rvalid = 1'b1;
        ifa.imem_rdata  = pend_a[0].data;
        void'(pend_a.pop_front());
      end else begin
        ifa.imem_rvalid = 1'b0;
      end
    end
  end

  // Memory B: fixed 1-cycle latency.
  logic        pend_b;
  logic [63:0] pend_addr_b;
  always @(negedge clk) begin
    pend_b      = ifb.imem_req;
    pend_addr_b = ifb.imem_addr;
  end

  initial begin
    ifb.imem_rvalid = 1'b0;
    ifb.imem_rdata  = '0;
    forever begin
      @(posedge clk);
      #1;
      ifb.imem_rvalid = pend_b;
      ifb.imem_rdata  = mem_word(pend_addr_b);
    end
  end

  // Monitors: every request and every newly presented instruction is scored.
  logic prev_valid_a = 1'b0;
  logic prev_valid_b = 1'b0;

  always @(negedge clk) begin
    if (ifa.imem_req) begin
      if (exp_req_a.size() == 0) chk("a_unexpected_req", ifa.imem_addr, 64'hDEAD_DEAD_DEAD_DEAD);
      else chk("a_req_addr", ifa.imem_addr, exp_req_a.pop_front());
    end
    if (ifa.if_valid && !prev_valid_a) begin
      if (exp_inst_a.size() == 0) begin
        chk("a_unexpected_inst", {32'h0, ifa.if_inst}, 64'hDEAD_DEAD_DEAD_DEAD);
      end else begin
        inst_t e;
        e = exp_inst_a.pop_front();
        chk("a_inst", {32'h0, ifa.if_inst}, {32'h0, e.inst});
        chk("a_pc", ifa.if_pc, e.pc);
      end
    end
    prev_valid_a = ifa.if_valid;
  end

  always @(negedge clk) begin
    if (ifb.imem_req && exp_req_b.size() != 0) chk("b_req_addr", ifb.imem_addr, exp_req_b.pop_front());
    if (ifb.if_valid && !prev_valid_b && exp_inst_b.size() != 0) begin
      inst_t e;
      e = exp_inst_b.pop_front();
      chk("b_inst", {32'h0, ifb.if_inst}, {32'h0, e.inst});
      chk("b_pc", ifb.if_pc, e.pc);
    end
    prev_valid_b = ifb.if_valid;
  end

  task automatic chk_reset_a(input string tag);
    chk({tag, "_req"},   {63'h0, ifa.imem_req}, 64'h0);
    chk({tag, "_addr"},  ifa.imem_addr, 64'h0);
    chk({tag, "_valid"}, {63'h0, ifa.if_valid}, 64'h0);
    chk({tag, "_inst"},  {32'h0, ifa.if_inst}, {32'h0, NOP});
    chk({tag, "_pc"},    ifa.if_pc, 64'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    arst               = 1'b1;
    arst_b             = 1'b1;
    ifa.stall          = 1'b0;
    ifa.redirect_valid = 1'b0;
    ifa.redirect_pc    = '0;
    ifb.stall          = 1'b0;
    ifb.redirect_valid = 1'b0;
    ifb.redirect_pc    = '0;
    repeat (3) @(negedge clk);
    chk_reset_a("reset");
    chk("b_reset_addr", ifb.imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);

    // Bring-up: request in cycle 1, instruction in cycle 3, then addr 4.
    exp_req_a.push_back(64'h0);
    exp_req_a.push_back(64'h4);
    exp_inst_a.push_back('{inst: 32'h0050_0093, pc: 64'h0});
    exp_inst_a.push_back('{inst: 32'h0000_0043, pc: 64'h4});
    exp_req_b.push_back(64'hFFFF_FFFF_FFFF_FFFC);
    exp_req_b.push_back(64'h0);
    exp_inst_b.push_back('{inst: 32'hFFFF_FFC3, pc: 64'hFFFF_FFFF_FFFF_FFFC});
    exp_inst_b.push_back('{inst: 32'h0050_0093, pc: 64'h0});
    arst   = 1'b0;
    arst_b = 1'b0;
    #1 chk("c0_req", {63'h0, ifa.imem_req}, 64'h0);
    @(negedge clk);
    chk("c1_req", {63'h0, ifa.imem_req}, 64'h1);
    @(negedge clk);
    chk("c2_valid", {63'h0, ifa.if_valid}, 64'h0);
    @(negedge clk);
    chk("c3_valid", {63'h0, ifa.if_valid}, 64'h1);

    // Stall for 5 cycles in FULL, then release into a request for addr 8.
    wait_valid(20, "wait_inst4");
    ifa.stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", {63'h0, ifa.if_valid}, 64'h1);
      chk("stall_inst", {32'h0, ifa.if_inst}, 64'h43);
      chk("stall_pc", ifa.if_pc, 64'h4);
      chk("stall_req", {63'h0, ifa.imem_req}, 64'h0);
    end
    exp_req_a.push_back(64'h8);
    exp_req_a.push_back(64'h100);
    exp_inst_a.push_back('{inst: 32'h0000_1003, pc: 64'h100});
    ifa.stall = 1'b0;
    lat       = 3;
    @(negedge clk);
    chk("release_req", {63'h0, ifa.imem_req}, 64'h1);
    chk("release_addr", ifa.imem_addr, 64'h8);

    // Redirect in the same cycle as the addr-8 request; its response is dropped.
    ifa.redirect_valid = 1'b1;
    ifa.redirect_pc    = 64'h100;
    @(negedge clk);
    ifa.redirect_valid = 1'b0;
    chk("flush_valid", {63'h0, ifa.if_valid}, 64'h0);
    wait_valid(40, "wait_inst100");

    // Redirect while REQ at 0x104, then a 1-cycle response lands in FLUSH.
    exp_req_a.push_back(64'h104);
    exp_req_a.push_back(64'h20);
    exp_inst_a.push_back('{inst: 32'h0000_0203, pc: 64'h20});
    lat = 1;
    wait_req(10, "wait_req104");
    ifa.redirect_valid = 1'b1;
    ifa.redirect_pc    = 64'h20;
    @(negedge clk);
    ifa.redirect_valid = 1'b0;
    wait_valid(20, "wait_inst20");
    chk("full20_pc", ifa.if_pc, 64'h20);

    // Redirect beats stall; unaligned target 0x203 fetches from 0x200.
    exp_req_a.push_back(64'h200);
    exp_inst_a.push_back('{inst: 32'h0000_2003, pc: 64'h200});
    ifa.stall          = 1'b1;
    ifa.redirect_valid = 1'b1;
    ifa.redirect_pc    = 64'h203;
    @(negedge clk);
    ifa.redirect_valid = 1'b0;
    ifa.stall          = 1'b0;
    chk("redir_stall_valid", {63'h0, ifa.if_valid}, 64'h0);
    chk("redir_stall_inst", {32'h0, ifa.if_inst}, {32'h0, NOP});
    chk("redir_stall_req", {63'h0, ifa.imem_req}, 64'h1);
    chk("redir_stall_addr", ifa.imem_addr, 64'h200);
    wait_valid(20, "wait_inst200");

    // Reset pulse in WAIT: the late response hits the first REQ and is ignored.
    exp_req_a.push_back(64'h204);
    lat = 3;
    wait_req(10, "wait_req204");
    @(negedge clk);
    exp_req_a.push_back(64'h0);
    exp_inst_a.push_back('{inst: 32'h0050_0093, pc: 64'h0});
    arst = 1'b1;
    #1 chk_reset_a("arst");
    @(negedge clk);
    arst = 1'b0;
    wait_valid(40, "wait_restart");
    ifa.stall = 1'b1;
    repeat (4) @(negedge clk);

    chk("a_req_left", 64'(exp_req_a.size()), 64'h0);
    chk("a_inst_left", 64'(exp_inst_a.size()), 64'h0);
    chk("b_req_left", 64'(exp_req_b.size()), 64'h0);
    chk("b_inst_left", 64'(exp_inst_b.size()), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
